// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_write_arbiter
// Purpose  : Writeback arbiter for the physical register file write ports.
//            Each of SRC_NUM execution-unit writeback sources feeds a small
//            FIFO. Every cycle a round-robin arbiter picks up to WRITE_PORT
//            non-empty FIFO heads and loads them into registered write ports.
//            Ports are filled from port 0 upward, in priority order.
// Ports    : clk        - clock
//            rst        - asynchronous, active-low reset
//            src_valid  - [SRC_NUM] source i presents a result
//            src_ready  - [SRC_NUM] source i FIFO is not full
//            src_preg   - [SRC_NUM*PREG_WIDTH] destination physical register
//            src_data   - [SRC_NUM*XLEN] result value
//            we         - [WRITE_PORT] registered regfile write enable
//            waddr      - [WRITE_PORT*PREG_WIDTH] registered write address
//            wdata      - [WRITE_PORT*XLEN] registered write data
// Revision : 1.0 - initial release
// ============================================================================

`ifndef PREG_WIDTH
`define PREG_WIDTH 7
`endif
`ifndef XLEN
`define XLEN 64
`endif

module wb_write_arbiter #(
  parameter int SRC_NUM    = 6,
  parameter int WRITE_PORT = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int PREG_WIDTH = `PREG_WIDTH,
  parameter int XLEN       = `XLEN
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [SRC_NUM-1:0]               src_valid,
  output logic [SRC_NUM-1:0]               src_ready,
  input  logic [SRC_NUM*PREG_WIDTH-1:0]    src_preg,
  input  logic [SRC_NUM*XLEN-1:0]          src_data,
  output logic [WRITE_PORT-1:0]            we,
  output logic [WRITE_PORT*PREG_WIDTH-1:0] waddr,
  output logic [WRITE_PORT*XLEN-1:0]       wdata
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int RR_W    = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;
  localparam int ENTRY_W = PREG_WIDTH + XLEN;

  // FIFO status and heads, gathered per source for the arbiter
  logic [SRC_NUM-1:0] push;
  logic [SRC_NUM-1:0] grant;
  logic [SRC_NUM-1:0] nonempty;
  logic [ENTRY_W-1:0] head       [SRC_NUM];
  logic [CNT_W-1:0]   fifo_count [SRC_NUM];

  // Arbiter results
  logic [RR_W-1:0]       rr_ptr;
  logic [RR_W-1:0]       rr_next;
  logic                  any_grant;
  logic [WRITE_PORT-1:0] port_valid;
  logic [ENTRY_W-1:0]    port_entry [WRITE_PORT];

  // --------------------------------------------------------------------------
  // Per-source FIFOs
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < SRC_NUM; i++) begin : g_src
      logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
      logic [PTR_W-1:0]   wr_ptr;
      logic [PTR_W-1:0]   rd_ptr;
      logic [CNT_W-1:0]   count;

      // Ready comes only from the registered count, so a full FIFO refuses
      // a push even in a cycle where it is also being popped.
      assign src_ready[i]  = (count != CNT_W'(FIFO_DEPTH));
      assign nonempty[i]   = (count != '0);
      assign push[i]       = src_valid[i] & src_ready[i];
      assign head[i]       = mem[rd_ptr];
      assign fifo_count[i] = count;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end else begin
          if (push[i]) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
          end
          if (grant[i]) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
          end
          case ({push[i], grant[i]})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
          endcase
        end
      end

      // Storage needs no reset: the count alone says which slots are live.
      always_ff @(posedge clk) begin
        if (push[i]) begin
          mem[wr_ptr] <= {src_preg[i*PREG_WIDTH +: PREG_WIDTH],
                          src_data[i*XLEN +: XLEN]};
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Round-robin arbiter
  // Every source gets its distance from rr_ptr (its priority position). A
  // non-empty source's rank is the number of non-empty sources ahead of it;
  // rank < WRITE_PORT means granted, and the rank is also its port number.
  // Working per source with constant indices keeps the logic a flat
  // compare/count network instead of a variable-indexed search.
  // --------------------------------------------------------------------------
  always_comb begin
    int pos  [SRC_NUM];
    int rank [SRC_NUM];
    int best_pos;
    int best_src;

    grant      = '0;
    port_valid = '0;
    any_grant  = 1'b0;
    best_pos   = -1;
    best_src   = 0;
    for (int k = 0; k < WRITE_PORT; k++) begin
      port_entry[k] = '0;
    end

    for (int i = 0; i < SRC_NUM; i++) begin
      if (i >= int'(rr_ptr)) begin
        pos[i] = i - int'(rr_ptr);
      end else begin
        pos[i] = i + SRC_NUM - int'(rr_ptr);
      end
    end

    for (int i = 0; i < SRC_NUM; i++) begin
      rank[i] = 0;
      for (int j = 0; j < SRC_NUM; j++) begin
        if (nonempty[j] && (pos[j] < pos[i])) begin
          rank[i] = rank[i] + 1;
        end
      end
      grant[i] = nonempty[i] && (rank[i] < WRITE_PORT);
    end

    // Route each granted head to the port matching its rank, and remember
    // the granted source furthest along the priority order.
    for (int i = 0; i < SRC_NUM; i++) begin
      if (grant[i]) begin
        any_grant = 1'b1;
        if (pos[i] > best_pos) begin
          best_pos = pos[i];
          best_src = i;
        end
        for (int k = 0; k < WRITE_PORT; k++) begin
          if (rank[i] == k) begin
            port_valid[k] = 1'b1;
            port_entry[k] = head[i];
          end
        end
      end
    end

    if (best_src == SRC_NUM - 1) begin
      rr_next = '0;
    end else begin
      rr_next = RR_W'(best_src + 1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= rr_next;
    end
  end

  // --------------------------------------------------------------------------
  // Registered write ports. An idle port drops we but keeps its last
  // address/data so the bus does not toggle needlessly.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we    <= '0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      for (int k = 0; k < WRITE_PORT; k++) begin
        we[k] <= port_valid[k];
        if (port_valid[k]) begin
          waddr[k*PREG_WIDTH +: PREG_WIDTH] <= port_entry[k][ENTRY_W-1 -: PREG_WIDTH];
          wdata[k*XLEN +: XLEN]             <= port_entry[k][XLEN-1:0];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_write_arbiter
// Purpose  : Directed self-checking bench for wb_write_arbiter
//            (SRC_NUM=6, WRITE_PORT=4, FIFO_DEPTH=2, PREG_WIDTH=7, XLEN=64).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_wb_write_arbiter;

  localparam int NS = 6;
  localparam int NP = 4;
  localparam int FD = 2;
  localparam int PW = 7;
  localparam int XL = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NS-1:0]   src_valid;
  logic [NS-1:0]   src_ready;
  logic [NS*PW-1:0] src_preg;
  logic [NS*XL-1:0] src_data;
  logic [NP-1:0]   we;
  logic [NP*PW-1:0] waddr;
  logic [NP*XL-1:0] wdata;

  int n_checks = 0;
  int n_fail   = 0;

  wb_write_arbiter #(
    .SRC_NUM    (NS),
    .WRITE_PORT (NP),
    .FIFO_DEPTH (FD),
    .PREG_WIDTH (PW),
    .XLEN       (XL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_preg  (src_preg),
    .src_data  (src_data),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [PW-1:0] p, input logic [XL-1:0] d);
    src_preg[i*PW +: PW] = p;
    src_data[i*XL +: XL] = d;
  endtask

  function automatic logic [PW-1:0] wa(input int k);
    return waddr[k*PW +: PW];
  endfunction

  function automatic logic [XL-1:0] wd(input int k);
    return wdata[k*XL +: XL];
  endfunction

  initial begin
    src_valid = '0;
    src_preg  = '0;
    src_data  = '0;

    // ---------------- reset state ----------------
    #2;
    chk("reset_we",    64'(we), 64'd0);
    chk("reset_waddr", 64'(waddr), 64'd0);
    chk("reset_wdata", 64'(wdata != '0), 64'd0);
    chk("reset_ready", 64'(src_ready), 64'h3f);
    chk("reset_rr",    64'(dut.rr_ptr), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    tick;

    // ---------------- single-source stream (source 3) ----------------
    src_valid = 6'b001000;
    drive(3, 7'd5, 64'hA);
    tick;                                   // edge 0: push 5/A
    chk("ss_e0_we", 64'(we), 64'd0);
    drive(3, 7'd7, 64'hB);
    tick;                                   // edge 1: push 7/B, write 5/A
    chk("ss_e1_we",    64'(we), 64'b0001);
    chk("ss_e1_waddr", 64'(wa(0)), 64'd5);
    chk("ss_e1_wdata", wd(0), 64'hA);
    chk("ss_e1_cnt3",  64'(dut.fifo_count[3]), 64'd1);
    src_valid = '0;
    tick;                                   // edge 2: write 7/B
    chk("ss_e2_we",    64'(we), 64'b0001);
    chk("ss_e2_waddr", 64'(wa(0)), 64'd7);
    chk("ss_e2_wdata", wd(0), 64'hB);
    tick;
    chk("ss_idle_we",  64'(we), 64'd0);
    chk("ss_rr",       64'(dut.rr_ptr), 64'd4);
    chk("ss_cnt3",     64'(dut.fifo_count[3]), 64'd0);

    // ---------------- push/pop same cycle (source 0) ----------------
    src_valid = 6'b000001;
    drive(0, 7'd20, 64'h200);
    tick;                                   // push only
    drive(0, 7'd21, 64'h201);
    tick;                                   // push + pop
    chk("pp_e1_cnt",   64'(dut.fifo_count[0]), 64'd1);
    chk("pp_e1_ready", 64'(src_ready[0]), 64'd1);
    chk("pp_e1_waddr", 64'(wa(0)), 64'd20);
    chk("pp_e1_wdata", wd(0), 64'h200);
    drive(0, 7'd22, 64'h202);
    tick;                                   // push + pop
    chk("pp_e2_cnt",   64'(dut.fifo_count[0]), 64'd1);
    chk("pp_e2_ready", 64'(src_ready[0]), 64'd1);
    chk("pp_e2_wdata", wd(0), 64'h201);
    src_valid = '0;
    tick;                                   // pop only
    chk("pp_e3_cnt",   64'(dut.fifo_count[0]), 64'd0);
    chk("pp_e3_we",    64'(we), 64'b0001);
    chk("pp_e3_wdata", wd(0), 64'h202);
    tick;
    chk("pp_idle_we",  64'(we), 64'd0);

    // ---------------- reset mid-traffic ----------------
    src_valid = 6'h3f;
    for (int i = 0; i < NS; i++) drive(i, PW'(30 + i), XL'(64'h300 + i));
    tick;
    tick;
    chk("mid_busy_we", 64'(we), 64'hf);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_we",    64'(we), 64'd0);
    chk("mid_rst_ready", 64'(src_ready), 64'h3f);
    chk("mid_rst_waddr", 64'(waddr), 64'd0);
    chk("mid_rst_rr",    64'(dut.rr_ptr), 64'd0);
    src_valid = '0;
    @(posedge clk);
    #3 rst = 1'b1;
    tick;
    tick;
    chk("mid_post_we", 64'(we), 64'd0);

    // ---------------- oversubscription ----------------
    src_valid = 6'h3f;
    for (int i = 0; i < NS; i++) drive(i, PW'(10 + i), XL'(64'h100 + i));
    tick;                                   // edge 0: all push
    src_valid = '0;
    chk("os_e0_we", 64'(we), 64'd0);
    tick;                                   // edge 1
    chk("os_e1_we", 64'(we), 64'hf);
    for (int k = 0; k < NP; k++) begin
      chk("os_e1_waddr", 64'(wa(k)), 64'(10 + k));
      chk("os_e1_wdata", wd(k), 64'(64'h100 + k));
    end
    chk("os_e1_rr", 64'(dut.rr_ptr), 64'd4);
    tick;                                   // edge 2
    chk("os_e2_we",     64'(we), 64'b0011);
    chk("os_e2_waddr0", 64'(wa(0)), 64'd14);
    chk("os_e2_wdata0", wd(0), 64'h104);
    chk("os_e2_waddr1", 64'(wa(1)), 64'd15);
    chk("os_e2_wdata1", wd(1), 64'h105);
    chk("os_e2_hold2",  64'(wa(2)), 64'd12);
    chk("os_e2_hold3",  wd(3), 64'h103);
    chk("os_e2_rr",     64'(dut.rr_ptr), 64'd0);

    // ---------------- saturation / full FIFO / scoreboard ----------------
    begin
      int cnt  [NS];
      int wseq [NS];
      int rseq [NS];
      int gr   [NS];
      int wr   [NS];
      logic [NS-1:0] pushed;
      logic [NS-1:0] exp_ready;
      logic [XL-1:0] d;
      logic [PW-1:0] exp_p;
      int s;
      int saw_full;
      saw_full = 0;
      for (int i = 0; i < NS; i++) begin
        cnt[i] = 0; wseq[i] = 0; rseq[i] = 0; gr[i] = 0;
      end
      for (int cyc = 0; cyc < 40; cyc++) begin
        pushed = '0;
        for (int i = 0; i < NS; i++) begin
          src_valid[i] = (cyc < 30);
          drive(i, PW'(i * 16 + (wseq[i] & 15)), (XL'(i) << 32) | XL'(wseq[i]));
          exp_ready[i] = (cnt[i] != FD);
          if (cyc < 30 && cnt[i] != FD) pushed[i] = 1'b1;
        end
        chk("sat_ready", 64'(src_ready), 64'(exp_ready));
        if (exp_ready != 6'h3f) saw_full = 1;
        tick;
        for (int i = 0; i < NS; i++) begin
          if (pushed[i]) wseq[i]++;
          wr[i] = 0;
        end
        if (cyc >= 1 && cyc <= 30) chk("sat_we_all", 64'(we), 64'hf);
        for (int k = 0; k < NP; k++) begin
          if (we[k]) begin
            d = wd(k);
            s = int'(d[39:32]);
            if (s >= NS) begin
              chk("sat_sb_src", 64'(s), 64'd0);
            end else begin
              exp_p = PW'(s * 16 + (rseq[s] & 15));
              chk("sat_sb_data",  d, (64'(s) << 32) | 64'(rseq[s]));
              chk("sat_sb_waddr", 64'(wa(k)), 64'(exp_p));
              rseq[s]++;
              wr[s]++;
              if (cyc >= 1 && cyc <= 30) gr[s]++;
            end
          end
        end
        for (int i = 0; i < NS; i++) cnt[i] = cnt[i] + int'(pushed[i]) - wr[i];
      end
      src_valid = '0;
      chk("sat_ready_toggled", 64'(saw_full), 64'd1);
      for (int i = 0; i < NS; i++) begin
        chk("sat_grants", 64'(gr[i] >= 19 && gr[i] <= 21), 64'd1);
        chk("sat_drained", 64'(rseq[i]), 64'(wseq[i]));
      end
      chk("sat_final_we", 64'(we), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Writeback arbiter that drives the physical register file's write ports. It collects results from SRC_NUM execution-unit writeback sources, each buffered in a small per-source FIFO, and round-robin arbitrates them onto WRITE_PORT registered write ports (we/waddr/wdata). It sits between the execution units and the integer or FP regfile, and is the producer side of the regfile write interface.

## Interface
- SRC_NUM, 6, number of writeback sources
- WRITE_PORT, 4, number of regfile write ports driven; must be ≤ SRC_NUM
- FIFO_DEPTH, 2, entries per source FIFO; power of two, ≥ 2
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- src_valid  in  SRC_NUM  source i presents a result
- src_ready  out  SRC_NUM  source i FIFO can accept; equals !full[i]
- src_preg  in  SRC_NUM×`PREG_WIDTH  destination physical register
- src_data  in  SRC_NUM×`XLEN  result value
- we  out  WRITE_PORT  regfile write enable, registered
- waddr  out  WRITE_PORT×`PREG_WIDTH  write address, registered
- wdata  out  WRITE_PORT×`XLEN  write data, registered

## Operation
- Push: source i enqueues {src_preg, src_data} on any rising edge where src_valid[i] && src_ready[i].
- src_ready[i] depends only on the registered count: a full FIFO does not accept a push, even in a cycle where it is popped.
- Per-source FIFO:
  - Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - The count is log2(FIFO_DEPTH)+1 bits.
  - A push and a pop in the same cycle leave the count unchanged.
- Arbitration is combinational and runs every cycle over the FIFO heads:
  - Candidate set: all non-empty FIFOs.
  - Priority order: rr_ptr, rr_ptr+1, …, wrapping modulo SRC_NUM.
  - Grant the first min(WRITE_PORT, candidates) sources in priority order.
  - The k-th granted source maps to port k, so ports fill from port 0 upward.
  - Every granted FIFO pops on the next edge.
- Port registers:
  - Port k loads {1, head preg, head data} when granted.
  - An ungranted port loads we=0; its waddr and wdata hold their previous values.
- rr_ptr (log2(SRC_NUM) bits):
  - If any grant occurs, rr_ptr ← (index of the last granted source + 1) mod SRC_NUM.
  - If there is no grant, rr_ptr is unchanged.
- No flush input: squashed results still write the regfile. This is harmless because their pregs are unreferenced.
- Two in-flight results never target the same preg; the block does not check for this.

## Timing
- Reset (rst=0), applied asynchronously at any time, including mid-traffic:
  - we=0, waddr=0, wdata=0.
  - All FIFOs empty; rr_ptr=0.
  - src_ready is all ones, both during and after reset.
- Latency:
  - A push accepted at edge E is arbitrated in the cycle after E.
  - That result appears on we/waddr/wdata after edge E+1, i.e. 2 cycles from handshake to regfile write.
- Throughput: up to WRITE_PORT writes per cycle, up to 1 per source per cycle.
- Backpressure: a source that is granted every cycle sustains 1 push per cycle with no src_ready bubble when FIFO_DEPTH ≥ 2.
- Fairness: every non-empty source is granted within ceil(SRC_NUM/WRITE_PORT) cycles.
- Boundaries:
  - Count = FIFO_DEPTH: src_ready=0.
  - Count = 0: the source is not a candidate.
  - rr_ptr at SRC_NUM-1 wraps to 0.
  - When rr_ptr lands on an empty source, the search simply skips ahead.

## Test plan
- Reset mid-traffic:
  - Drive all sources busy, then pull rst low between edges.
  - Required: we=0 immediately; src_ready=6'b111111.
  - After release, the first write appears only from a new push, 2 cycles later.
- Single-source stream:
  - Source 3 pushes (preg 5, 0xA) at edge 0 and (preg 7, 0xB) at edge 1.
  - Required: after edge 1, we[0]=1, waddr[0]=5, wdata[0]=0xA; after edge 2, port 0 shows 7/0xB.
  - Ports 1–3 stay at we=0 throughout.
- Oversubscription:
  - With rr_ptr=0, all 6 sources push once at edge 0.
  - Required after edge 1: ports 0–3 carry sources 0–3, and rr_ptr becomes 4.
  - Required after edge 2: ports 0–1 carry sources 4–5, ports 2–3 have we=0, and rr_ptr becomes 0.
- Saturation fairness:
  - All 6 sources keep src_valid=1 for 30 cycles.
  - Required: exactly 4 writes every cycle once in steady state.
  - Each source receives 20±1 grants.
  - src_ready toggles, and no result is lost or duplicated (scoreboard check).
- Push/pop same cycle:
  - Source 0 holds 1 entry and is granted while pushing a new entry.
  - Required: the count stays 1, src_ready stays 1, and the writes emerge in push order.
- Full FIFO:
  - Drive 6 sources continuously.
  - Required: on each cycle where a FIFO count is 2, that source's src_ready=0 even if the source is popped that cycle.
  - A src_valid held high while src_ready=0 does not enqueue.
